packet_ctrl: RTL

Serial packet controller for the inbound sensor link. It assembles LSB-first bytes from the qualified serial stream and hunts for a header byte. After a header it sequences a fixed-length payload: store-type packets are written byte-by-byte into the downstream data RAM, and skip-type packets are consumed and discarded. It sits between the serial front end and the single-port packet RAM and is the only RAM write master.

---
 rtl/packet_ctrl_if.sv | 36 +++
 rtl/packet_ctrl.sv | 122 ++++++++++++
 2 files changed

// File: rtl/packet_ctrl_if.sv
// rtl/packet_ctrl_if.sv - serial-in / RAM-write-out bundle for packet_ctrl
//
// Purpose: groups the qualified serial input and the RAM/status outputs of
// packet_ctrl so that they can be passed around as a single port.
// Signals:
//   serial_data  serial bit, meaningful only while data_ena=1
//   data_ena     bit qualifier, one bit per clock while high
//   ram_wr       one-cycle RAM write strobe
//   ram_addr     write address, valid while ram_wr=1
//   ram_data     write data, valid while ram_wr=1
//   pkt_done     one-cycle pulse at the end of every packet
//   pkt_cnt      completed store-type packet count (wraps)
//   busy         high while a payload is being sequenced
// Modports: master = controller view, slave = serial source / RAM side view.
interface packet_ctrl_if #(
  parameter int ADDR_W = 11
);
  logic              serial_data;
  logic              data_ena;
  logic              ram_wr;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_data;
  logic              pkt_done;
  logic [7:0]        pkt_cnt;
  logic              busy;

  modport master (
    input  serial_data, data_ena,
    output ram_wr, ram_addr, ram_data, pkt_done, pkt_cnt, busy
  );

  modport slave (
    output serial_data, data_ena,
    input  ram_wr, ram_addr, ram_data, pkt_done, pkt_cnt, busy
  );
endinterface

// File: rtl/packet_ctrl.sv
// rtl/packet_ctrl.sv - serial packet controller: byte assembly, header hunt, RAM writer
//
// Purpose: assembles LSB-first bytes from the qualified serial stream, hunts
// for a store or skip header, then sequences a fixed-length payload. Store
// payload bytes are written to the packet RAM at a free-running address;
// skip payload bytes are consumed silently.
// Ports:
//   clk_50   50 MHz clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      packet_ctrl_if.master (serial in, RAM write and status out)
module packet_ctrl #(
  parameter int         PAYLOAD_BYTES = 4,
  parameter int         ADDR_W        = 11,
  parameter logic [7:0] HDR_STORE     = 8'hA5,
  parameter logic [7:0] HDR_SKIP      = 8'hC3
) (
  input  logic                 clk_50,
  input  logic                 reset_n,
  packet_ctrl_if.master        bus
);

  localparam int PC_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam logic [PC_W-1:0] LAST_IDX = PC_W'(PAYLOAD_BYTES - 1);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    STORE = 2'd1,
    SKIP  = 2'd2
  } state_t;

  state_t            r_state;
  logic [2:0]        r_bit_cnt;
  // Only shreg[7:1] is kept: shreg[0] is shifted out by the next bit and
  // never reaches an assembled byte.
  logic [6:0]        r_shreg;
  logic [PC_W-1:0]   r_pay_cnt;
  logic [ADDR_W-1:0] r_addr;

  logic              r_ram_wr;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [7:0]        r_ram_data;
  logic              r_pkt_done;
  logic [7:0]        r_pkt_cnt;
  logic              r_busy;

  logic [7:0]        w_byte;
  logic              w_byte_done;
  logic              w_last;

  // Byte as it stands after shifting in the current bit.
  assign w_byte      = {bus.serial_data, r_shreg};
  assign w_byte_done = bus.data_ena && (r_bit_cnt == 3'd7);
  assign w_last      = (r_pay_cnt == LAST_IDX);

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= HUNT;
      r_bit_cnt  <= '0;
      r_shreg    <= '0;
      r_pay_cnt  <= '0;
      r_addr     <= '0;
      r_ram_wr   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_data <= '0;
      r_pkt_done <= 1'b0;
      r_pkt_cnt  <= '0;
      r_busy     <= 1'b0;
    end else begin
      // Strobes are single-cycle; ram_addr/ram_data simply hold.
      r_ram_wr   <= 1'b0;
      r_pkt_done <= 1'b0;

      if (bus.data_ena) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
        r_shreg   <= w_byte[7:1];
      end

      if (w_byte_done) begin
        case (r_state)
          HUNT: begin
            if (w_byte == HDR_STORE) begin
              r_state   <= STORE;
              r_pay_cnt <= '0;
              r_busy    <= 1'b1;
            end else if (w_byte == HDR_SKIP) begin
              r_state   <= SKIP;
              r_pay_cnt <= '0;
              r_busy    <= 1'b1;
            end
          end
          STORE, SKIP: begin
            if (r_state == STORE) begin
              r_ram_wr   <= 1'b1;
              r_ram_addr <= r_addr;
              r_ram_data <= w_byte;
              r_addr     <= r_addr + 1'b1;
            end
            if (w_last) begin
              r_pkt_done <= 1'b1;
              r_state    <= HUNT;
              r_busy     <= 1'b0;
              if (r_state == STORE) begin
                r_pkt_cnt <= r_pkt_cnt + 8'd1;
              end
            end else begin
              r_pay_cnt <= r_pay_cnt + 1'b1;
            end
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

  assign bus.ram_wr   = r_ram_wr;
  assign bus.ram_addr = r_ram_addr;
  assign bus.ram_data = r_ram_data;
  assign bus.pkt_done = r_pkt_done;
  assign bus.pkt_cnt  = r_pkt_cnt;
  assign bus.busy     = r_busy;

endmodule
